demux1to8_32b_stream: RTL and testbench

- Registered 1-to-8 demultiplexer for 32-bit words; the distribution counterpart of the 8-to-1 32-bit word mux.
- Takes one valid/ready input stream and a 3-bit destination select, and steers each accepted word into one of eight output channels.
- Each output channel has a 1-entry holding register with its own valid/ready handshake.
- Sits between a single producer (datapath/bus write side) and up to eight independent consumers.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_out_slot.sv | 32 +++
 rtl/demux1to8_32b_stream.sv | 64 ++++++
 tb/tb_demux1to8_32b_stream.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and the channel-slice helper for the 1-to-8 word demux.
// Slices the flattened multi-channel bus: bus[`DEMUX_SLICE(k, w)] selects channel k.
`ifndef DEMUX_SLICE
`define DEMUX_SLICE(k, w) (k)*(w) +: (w)
`endif

package demux_pkg;
    localparam int unsigned DEMUX_WIDTH = 32;
    localparam int unsigned DEMUX_SEL_W = 3;
    localparam int unsigned DEMUX_N     = 2**DEMUX_SEL_W;
endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid/ready handshake.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic             full,
    output logic [WIDTH-1:0] data_out,
    output logic             slot_ready
);

    // A fill wins over a drain in the same cycle, giving 1 word/cycle throughput.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            full     <= 1'b1;
            data_out <= data_in;
        end else if (out_ready) begin
            full     <= 1'b0;
        end
    end

    assign slot_ready = !full || out_ready;

endmodule

// File: rtl/demux1to8_32b_stream.sv
// Registered 1-to-8 stream demux: select decode and in_ready mux over eight slots.
// Optional broadcast input enabled by defining DEMUX1TO8_BCAST_EN.
module demux1to8_32b_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH,
    parameter int unsigned SEL_W = DEMUX_SEL_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [WIDTH-1:0]           in_data,
`ifdef DEMUX1TO8_BCAST_EN
    input  logic                       in_bcast,
`endif
    output logic [(2**SEL_W)-1:0]       out_valid,
    input  logic [(2**SEL_W)-1:0]       out_ready,
    output logic [(2**SEL_W)*WIDTH-1:0] out_data
);

    localparam int unsigned N = 2**SEL_W;

    logic [N-1:0] slot_ready;
    logic [N-1:0] load;

    always_comb begin
        load     = '0;
        in_ready = slot_ready[in_sel];
`ifdef DEMUX1TO8_BCAST_EN
        if (in_bcast) begin
            in_ready = &slot_ready;
        end
        if (in_valid && in_ready) begin
            if (in_bcast) begin
                load = '1;
            end else begin
                load[in_sel] = 1'b1;
            end
        end
`else
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
`endif
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[k]),
            .data_in    (in_data),
            .out_ready  (out_ready[k]),
            .full       (out_valid[k]),
            .data_out   (out_data[`DEMUX_SLICE(k, WIDTH)]),
            .slot_ready (slot_ready[k])
        );
    end

endmodule

// File: tb/tb_demux1to8_32b_stream.sv
// Scoreboard bench for demux1to8_32b_stream: per-channel expected queues, random traffic.
module tb_demux1to8_32b_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_sel = '0;
    logic [31:0]  in_data = '0;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready = '0;
    logic [255:0] out_data;
`ifdef DEMUX1TO8_BCAST_EN
    logic         in_bcast = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Model: which channels hold an un-consumed word, and the words per channel in order.
    logic [7:0]  occ = '0;
    logic [31:0] exp_q [8][$];
    logic        last_acc = 1'b0;

    always #5 clk = ~clk;

    demux1to8_32b_stream #(
        .WIDTH(32),
        .SEL_W(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
`ifdef DEMUX1TO8_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Producer-side bookkeeping at the negedge, before the next rising edge commits.
    task automatic book();
        logic exp_rdy;
        if (!rst_n) begin
            occ      = '0;
            last_acc = 1'b0;
            for (int k = 0; k < 8; k++) exp_q[k].delete();
            return;
        end
        exp_rdy = !occ[in_sel] || out_ready[in_sel];
        chk("in_ready", 256'(in_ready), 256'(exp_rdy));
        chk("out_valid", 256'(out_valid), 256'(occ));
        last_acc = in_valid && exp_rdy;
        for (int k = 0; k < 8; k++)
            if (occ[k] && out_ready[k]) occ[k] = 1'b0;
        if (last_acc) begin
            occ[in_sel] = 1'b1;
            exp_q[in_sel].push_back(in_data);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d,
                         input logic [7:0] r, input logic rn);
        @(posedge clk);
        #1;
        rst_n     = rn;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        book();
    endtask

    // Monitor: every consumed word must be the oldest expected word for its channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word ch%0d: got %h want none", k, out_data[k*32 +: 32]);
                    end else begin
                        chk($sformatf("data_ch%0d", k), 256'(out_data[k*32 +: 32]), 256'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        logic        v;
        logic [2:0]  s;
        logic [31:0] d;
        logic [7:0]  r;
        logic        pend;

        // Reset held two cycles with in_valid high.
        drive(1'b1, 3'd1, 32'h1234_5678, 8'h00, 1'b0);
        drive(1'b1, 3'd1, 32'h1234_5678, 8'h00, 1'b0);
        drive(1'b0, 3'd0, 32'h0, 8'h00, 1'b1);
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_out_data", out_data, 256'(0));
        chk("reset_in_ready", 256'(in_ready), 256'(1));

        // Unicast to channel 5, then it drains.
        drive(1'b1, 3'd5, 32'hDEAD_BEEF, 8'hFF, 1'b1);
        drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b1);
        chk("uni_ch5_data", 256'(out_data[191:160]), 256'(32'hDEAD_BEEF));
        drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b1);

        // Backpressure on ch2 and no head-of-line blocking via ch6.
        drive(1'b1, 3'd2, 32'h1, 8'hBB, 1'b1);
        drive(1'b1, 3'd2, 32'h2, 8'hBB, 1'b1);
        chk("bp_stalled", 256'(last_acc), 256'(0));
        drive(1'b1, 3'd6, 32'hA5, 8'hBB, 1'b1);
        drive(1'b0, 3'd0, 32'h0, 8'hBB, 1'b1);
        chk("hol_ch2", 256'(out_data[95:64]), 256'(32'h1));
        chk("hol_ch6", 256'(out_data[223:192]), 256'(32'hA5));
        drive(1'b1, 3'd2, 32'h2, 8'hFF, 1'b1);
        drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b1);
        chk("bp_ch2_new", 256'(out_data[95:64]), 256'(32'h2));

        // Back-to-back streaming into ch0.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'd0, 32'h10 + 32'(i), 8'h01, 1'b1);
        drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b1);
        drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b1);

        // Random traffic; producer holds its word until accepted.
        pend = 1'b0;
        v = 1'b0; s = '0; d = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                drive(1'b1, s, d, 8'h00, 1'b0);
                drive(1'b1, s, d, 8'h00, 1'b0);
                pend = 1'b0;
            end
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                s = 3'($urandom_range(0, 7));
                d = $urandom;
            end
            r = (i % 200 < 100) ? 8'($urandom) : 8'($urandom | $urandom);
            drive(v, s, d, r, 1'b1);
            pend = v && !last_acc;
        end

        // Drain everything and confirm nothing is left outstanding.
        for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b1);
        for (int k = 0; k < 8; k++)
            chk($sformatf("leftover_ch%0d", k), 256'(exp_q[k].size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
